// File: rtl/stone_ram_arbiter.sv
// Single-port stone RAM arbiter: loader (write), drawer (read) and rope (read/write)
// share one access per cycle, with an aging counter that keeps the rope from starving.
module stone_ram_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  input  logic              rope_req,
  input  logic              rope_we,
  input  logic [ADDR_W-1:0] rope_addr,
  input  logic [DATA_W-1:0] rope_wdata,
  output logic              rope_gnt,
  output logic              rope_rvalid,
  output logic [DATA_W-1:0] rope_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_DRAW,
    SRC_ROPE
  } src_t;

  state_t            state, state_nxt;
  src_t              issued, winner;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_elig, draw_elig, rope_elig;
  logic [DATA_W-1:0] draw_rdata_hold, rope_rdata_hold;

  // A requester being granted this cycle is still dropping its req, so it sits out.
  assign load_elig = load_req && !load_gnt;
  assign draw_elig = draw_req && !draw_gnt;
  assign rope_elig = rope_req && !rope_gnt;

  assign load_gnt = (state == S_ISSUE) && (issued == SRC_LOAD);
  assign draw_gnt = (state == S_ISSUE) && (issued == SRC_DRAW);
  assign rope_gnt = (state == S_ISSUE) && (issued == SRC_ROPE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    winner       = SRC_NONE;
    state_nxt    = S_IDLE;
    wait_cnt_nxt = wait_cnt;

    if (rope_elig && (wait_cnt == WAIT_MAX)) begin
      winner = SRC_ROPE;
    end else if (load_elig) begin
      winner = SRC_LOAD;
    end else if (draw_elig) begin
      winner = SRC_DRAW;
    end else if (rope_elig) begin
      winner = SRC_ROPE;
    end

    if (winner != SRC_NONE) begin
      state_nxt = S_ISSUE;
    end

    if (!rope_req || (winner == SRC_ROPE)) begin
      wait_cnt_nxt = '0;
    end else if (rope_elig && (wait_cnt != WAIT_MAX)) begin
      wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state           <= S_IDLE;
      issued          <= SRC_NONE;
      wait_cnt        <= '0;
      ram_address     <= '0;
      ram_data        <= '0;
      ram_wren        <= 1'b0;
      draw_rvalid     <= 1'b0;
      rope_rvalid     <= 1'b0;
      draw_rdata_hold <= '0;
      rope_rdata_hold <= '0;
    end else begin
      state    <= state_nxt;
      issued   <= winner;
      wait_cnt <= wait_cnt_nxt;
      ram_wren <= 1'b0;

      unique case (winner)
        SRC_LOAD: begin
          ram_address <= load_addr;
          ram_data    <= load_wdata;
          ram_wren    <= 1'b1;
        end
        SRC_DRAW: begin
          ram_address <= draw_addr;
        end
        SRC_ROPE: begin
          ram_address <= rope_addr;
          if (rope_we) begin
            ram_data <= rope_wdata;
            ram_wren <= 1'b1;
          end
        end
        default: ;
      endcase

      // Read data arrives one cycle after the granted address; writes never return data.
      draw_rvalid <= draw_gnt;
      rope_rvalid <= rope_gnt && !ram_wren;

      if (draw_rvalid) draw_rdata_hold <= ram_q;
      if (rope_rvalid) rope_rdata_hold <= ram_q;
    end
  end

  // RAM output passes straight through while valid; the hold copy keeps it stable afterwards.
  assign draw_rdata = draw_rvalid ? ram_q : draw_rdata_hold;
  assign rope_rdata = rope_rvalid ? ram_q : rope_rdata_hold;

endmodule
